// File: rtl/barrel_pkg.sv
// barrel_pkg: shared types and helpers for the barrel thread scheduler.
//   thread_state_t : per-thread scheduling state (RUN, WAIT, HALT)
//   PC_W           : program counter width
//   calc_tid_w()   : thread-id width for a given thread count
// Optional feature macro used by the design: BARREL_SCHED_SKIP_EN
package barrel_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } thread_state_t;

   localparam int unsigned PC_W = 32;

   function automatic int unsigned calc_tid_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/barrel_sched_rr_pick.sv
// rr_pick: round-robin picker. Grants the first requester strictly after
// i_last, wrapping around; i_last itself is considered last.
//   i_req   : request mask, one bit per thread
//   i_last  : index of the most recent grant
//   o_grant : one-hot grant
//   o_valid : at least one request was granted
// Only instantiated when BARREL_SCHED_SKIP_EN is defined.
module rr_pick
   import barrel_pkg::*;
#(
   parameter  int unsigned N = 4,
   localparam int unsigned W = calc_tid_w(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   output logic [N-1:0] o_grant,
   output logic         o_valid
);

   always_comb begin
      int unsigned idx;
      idx     = 0;
      o_grant = '0;
      o_valid = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (int'(i_last) + k) % N;
         if (!o_valid && i_req[idx]) begin
            o_grant[idx] = 1'b1;
            o_valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/barrel_sched.sv
// barrel_sched: barrel (interleaved multithread) issue scheduler.
// Keeps RUN/WAIT/HALT state, an in-flight flag and a PC per thread, offers
// one thread per cycle for issue and tracks retirement, wakeups and exit.
//   clk, resetn           : clock (rising edge), asynchronous active-low reset
//   issue_valid/tid/pc    : thread offered this cycle (combinational)
//   wb_valid/tid/next_pc  : retire event and resume PC
//   wb_wait, wb_halt      : retiring thread blocks / exits (halt wins)
//   wb_code               : exit code carried with wb_halt
//   wake_valid, wake_tid  : wake a WAIT thread
//   exit, exitcode        : all threads halted / first exit code (sticky)
// Macro BARREL_SCHED_SKIP_EN: skip non-issuable threads instead of issuing
// bubbles in a fixed rotation.
module barrel_sched
   import barrel_pkg::*;
#(
   parameter  int unsigned NTHREADS = 4,
   parameter  logic [31:0] RESET_PC = 32'h0,
   localparam int unsigned TID_W    = calc_tid_w(NTHREADS)
) (
   input  logic              clk,
   input  logic              resetn,
   output logic              issue_valid,
   output logic [TID_W-1:0]  issue_tid,
   output logic [PC_W-1:0]   issue_pc,
   input  logic              wb_valid,
   input  logic [TID_W-1:0]  wb_tid,
   input  logic [PC_W-1:0]   wb_next_pc,
   input  logic              wb_wait,
   input  logic              wb_halt,
   input  logic [31:0]       wb_code,
   input  logic              wake_valid,
   input  logic [TID_W-1:0]  wake_tid,
   output logic              exit,
   output logic [31:0]       exitcode
);

   thread_state_t       r_state [NTHREADS];
   logic [PC_W-1:0]     r_pc    [NTHREADS];
   logic [NTHREADS-1:0] r_busy;
   logic [TID_W-1:0]    r_slot;
   logic                r_exit;
   logic                r_halt_seen;
   logic [31:0]         r_exitcode;

   logic [NTHREADS-1:0] w_ready;
   logic [NTHREADS-1:0] w_wb_hit;
   logic [NTHREADS-1:0] w_wake_hit;
   logic                w_all_halt;
   logic                w_halt_ev;
   logic                w_issue;
   logic [TID_W-1:0]    w_tid;
   logic [TID_W-1:0]    w_slot_nxt;

   always_comb begin
      w_ready    = '0;
      w_wb_hit   = '0;
      w_wake_hit = '0;
      w_all_halt = 1'b1;
      for (int unsigned i = 0; i < NTHREADS; i++) begin
         w_ready[i]    = (r_state[i] == RUN) && !r_busy[i];
         // Retirements for threads with nothing in flight are discarded.
         w_wb_hit[i]   = wb_valid && (wb_tid == TID_W'(i)) && r_busy[i];
         w_wake_hit[i] = wake_valid && (wake_tid == TID_W'(i));
         w_all_halt    = w_all_halt && (r_state[i] == HALT);
      end
      w_halt_ev = wb_valid && wb_halt && r_busy[wb_tid];
   end

`ifdef BARREL_SCHED_SKIP_EN
   // r_slot holds the search start (one past the last grant), so the
   // picker's "last grant" is r_slot-1; reset value 0 makes thread 0 first.
   logic [NTHREADS-1:0] w_grant;
   logic                w_any;
   logic [TID_W-1:0]    w_last;

   assign w_last = r_slot - TID_W'(1);

   rr_pick #(.N(NTHREADS)) u_rr_pick (
      .i_req   (w_ready),
      .i_last  (w_last),
      .o_grant (w_grant),
      .o_valid (w_any)
   );

   always_comb begin
      w_tid = r_slot;
      for (int unsigned i = 0; i < NTHREADS; i++) begin
         if (w_grant[i]) w_tid = TID_W'(i);
      end
      w_issue    = w_any;
      w_slot_nxt = w_any ? (w_tid + TID_W'(1)) : r_slot;
   end
`else
   // NTHREADS is a power of two, so natural overflow wraps the rotation.
   always_comb begin
      w_tid      = r_slot;
      w_issue    = w_ready[r_slot];
      w_slot_nxt = r_slot + TID_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NTHREADS; i++) begin
            r_state[i] <= RUN;
            r_pc[i]    <= RESET_PC;
         end
         r_busy      <= '0;
         r_slot      <= '0;
         r_exit      <= 1'b0;
         r_halt_seen <= 1'b0;
         r_exitcode  <= '0;
      end else begin
         r_slot <= w_slot_nxt;
         for (int unsigned i = 0; i < NTHREADS; i++) begin
            // Issue needs busy clear, a retire needs busy set: never both.
            if (w_issue && (w_tid == TID_W'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (w_wb_hit[i]) begin
               r_busy[i] <= 1'b0;
            end

            if (w_wb_hit[i]) begin
               r_pc[i] <= wb_next_pc;
               if (wb_halt) begin
                  r_state[i] <= HALT;
               end else if (wb_wait && !w_wake_hit[i]) begin
                  r_state[i] <= WAIT;
               end else begin
                  // A wake racing the blocking retire keeps the thread running.
                  r_state[i] <= RUN;
               end
            end else if (w_wake_hit[i] && (r_state[i] == WAIT)) begin
               r_state[i] <= RUN;
            end
         end

         if (w_halt_ev && !r_halt_seen) begin
            r_halt_seen <= 1'b1;
            r_exitcode  <= wb_code;
         end

         r_exit <= r_exit || w_all_halt;
      end
   end

   assign issue_valid = w_issue;
   assign issue_tid   = w_tid;
   assign issue_pc    = r_pc[w_tid];
   assign exit        = r_exit;
   assign exitcode    = r_exitcode;

endmodule

// File: tb/tb_barrel_sched.sv
// Self-checking bench for barrel_sched (NTHREADS=4, RESET_PC=0).
module tb_barrel_sched;

   localparam int N = 4;
   localparam int S_RUN = 0, S_WAIT = 1, S_HALT = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        wb_valid = 1'b0, wb_wait = 1'b0, wb_halt = 1'b0, wake_valid = 1'b0;
   logic [1:0]  wb_tid = '0, wake_tid = '0;
   logic [31:0] wb_next_pc = '0, wb_code = '0;
   logic        issue_valid, exit;
   logic [1:0]  issue_tid;
   logic [31:0] issue_pc, exitcode;

   always #5 clk = ~clk;

   barrel_sched #(.NTHREADS(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .resetn(resetn),
      .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
      .wb_valid(wb_valid), .wb_tid(wb_tid), .wb_next_pc(wb_next_pc),
      .wb_wait(wb_wait), .wb_halt(wb_halt), .wb_code(wb_code),
      .wake_valid(wake_valid), .wake_tid(wake_tid),
      .exit(exit), .exitcode(exitcode)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out at %0t", name, $time);
   endtask

   // ---------------- reference model (thread-level rules) ----------------
   int          m_st   [N];
   bit          m_busy [N];
   logic [31:0] m_pc   [N];
   int          m_ptr;
   bit          m_exit, m_seen;
   logic [31:0] m_code;

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = S_RUN; m_busy[i] = 0; m_pc[i] = 32'h0;
      end
      m_ptr = 0; m_exit = 0; m_seen = 0; m_code = 32'h0;
   endfunction

   function automatic int m_pick();
`ifdef BARREL_SCHED_SKIP_EN
      for (int k = 0; k < N; k++) begin
         int t = (m_ptr + k) % N;
         if (m_st[t] == S_RUN && !m_busy[t]) return t;
      end
      return -1;
`else
      return (m_st[m_ptr] == S_RUN && !m_busy[m_ptr]) ? m_ptr : -1;
`endif
   endfunction

   // ---------------- retire engine: in-flight queue -----------------------
   typedef struct { int tid; int age; logic [31:0] pc; } inf_t;
   inf_t q[$];
   bit          ctl_wait[N], ctl_halt[N], ctl_wake[N], ctl_npc_en[N];
   logic [31:0] ctl_npc[N], ctl_code[N];
   bit          manual_wb = 0;
   bit          rand_mode = 0;
   int          retired_tid = -1;

   function automatic bit head_due();
      return (q.size() > 0) && (q[0].age >= 1);
   endfunction

   function automatic void ctl_clear(input int t);
      ctl_wait[t] = 0; ctl_halt[t] = 0; ctl_wake[t] = 0; ctl_npc_en[t] = 0;
      ctl_npc[t] = 0; ctl_code[t] = 0;
   endfunction

   // Called at a falling edge: drives retire, checks outputs, advances model,
   // crosses one rising edge and returns at the next falling edge.
   task automatic tick();
      int  t;
      bit  allh, wb_applied;
      retired_tid = -1;
      if (!manual_wb && head_due()) begin
         inf_t h = q.pop_front();
         wb_valid   = 1; wb_tid = 2'(h.tid);
         wb_next_pc = ctl_npc_en[h.tid] ? ctl_npc[h.tid] : h.pc + 32'd4;
         wb_wait    = ctl_wait[h.tid]; wb_halt = ctl_halt[h.tid]; wb_code = ctl_code[h.tid];
         if (ctl_wake[h.tid]) begin wake_valid = 1; wake_tid = 2'(h.tid); end
         retired_tid = h.tid;
         ctl_clear(h.tid);
      end else if (manual_wb && wb_valid) begin
         for (int i = 0; i < q.size(); i++)
            if (q[i].tid == int'(wb_tid)) begin q.delete(i); break; end
      end

      t = m_pick();
      chk("issue_valid", issue_valid, (t >= 0) ? 32'd1 : 32'd0);
      if (t >= 0) begin
         chk("issue_tid", issue_tid, t);
         chk("issue_pc", issue_pc, m_pc[t]);
      end
`ifndef BARREL_SCHED_SKIP_EN
      else chk("bubble_tid", issue_tid, m_ptr);
`endif
      chk("exit", exit, m_exit);
      chk("exitcode", exitcode, m_code);

      allh = 1;
      for (int i = 0; i < N; i++) if (m_st[i] != S_HALT) allh = 0;
      wb_applied = wb_valid && m_busy[wb_tid];
      if (wb_applied) begin
         m_pc[wb_tid]   = wb_next_pc;
         m_busy[wb_tid] = 0;
         if (wb_halt) begin
            m_st[wb_tid] = S_HALT;
            if (!m_seen) begin m_seen = 1; m_code = wb_code; end
         end else if (wb_wait && !(wake_valid && wake_tid == wb_tid)) m_st[wb_tid] = S_WAIT;
         else m_st[wb_tid] = S_RUN;
      end
      if (wake_valid && !(wb_applied && wake_tid == wb_tid) && m_st[wake_tid] == S_WAIT)
         m_st[wake_tid] = S_RUN;
      if (t >= 0) m_busy[t] = 1;
`ifdef BARREL_SCHED_SKIP_EN
      if (t >= 0) m_ptr = (t + 1) % N;
`else
      m_ptr = (m_ptr + 1) % N;
`endif
      m_exit = m_exit || allh;

      foreach (q[i]) q[i].age++;
      if (t >= 0) begin
         inf_t e;
         e.tid = t; e.age = 0; e.pc = m_pc[t];
         q.push_back(e);
         if (rand_mode) begin
            ctl_wait[t]   = ($urandom_range(0, 3) == 0);
            ctl_halt[t]   = ($urandom_range(0, 39) == 0);
            ctl_wake[t]   = ($urandom_range(0, 5) == 0);
            ctl_code[t]   = $urandom;
            ctl_npc_en[t] = $urandom_range(0, 1) == 1;
            ctl_npc[t]    = $urandom & 32'hFFFF_FFFC;
         end
      end

      @(posedge clk);
      @(negedge clk);
      wb_valid = 0; wb_wait = 0; wb_halt = 0; wb_tid = '0; wb_next_pc = '0; wb_code = '0;
      wake_valid = 0; wake_tid = '0;
      manual_wb = 0;
   endtask

   // Asynchronous reset pulse starting mid-low-phase; returns at a falling edge.
   task automatic pulse_reset();
      #2 resetn = 0;
      #1;
      chk("rst_exit", exit, 0);
      chk("rst_exitcode", exitcode, 0);
      chk("rst_issue_valid", issue_valid, 1);
      chk("rst_issue_tid", issue_tid, 0);
      chk("rst_issue_pc", issue_pc, 0);
      @(negedge clk);
      resetn = 1;
      m_reset();
      q.delete();
      for (int i = 0; i < N; i++) ctl_clear(i);
   endtask

   typedef struct {
      logic        wbv; logic [1:0] wbt; logic [31:0] npc;
      logic        ev;  logic [1:0] et;  logic [31:0] epc;
   } vec_t;
   vec_t tbl[5];

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt;
      bit found;
      logic [31:0] exp_pc2;

      for (int i = 0; i < N; i++) ctl_clear(i);
      m_reset();
      @(negedge clk);
      pulse_reset();

      // Reset release: retire each issue two cycles later at pc+4.
      tbl[0] = '{1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 32'h0};
      tbl[1] = '{1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 32'h0};
      tbl[2] = '{1'b1, 2'd0, 32'h4, 1'b1, 2'd2, 32'h0};
      tbl[3] = '{1'b1, 2'd1, 32'h4, 1'b1, 2'd3, 32'h0};
      tbl[4] = '{1'b1, 2'd2, 32'h4, 1'b1, 2'd0, 32'h4};
      for (int i = 0; i < 5; i++) begin
         manual_wb = 1;
         wb_valid = tbl[i].wbv; wb_tid = tbl[i].wbt; wb_next_pc = tbl[i].npc;
         chk("tbl_valid", issue_valid, tbl[i].ev);
         chk("tbl_tid", issue_tid, tbl[i].et);
         chk("tbl_pc", issue_pc, tbl[i].epc);
         tick();
      end

      // Thread 1 blocks, is not issued, then resumes at its new PC after wake.
      ctl_wait[1] = 1; ctl_npc_en[1] = 1; ctl_npc[1] = 32'h100;
      n = 0;
      while (m_st[1] != S_WAIT && n < 20) begin tick(); n++; end
      if (m_st[1] != S_WAIT) timeout("t1_wait");
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (issue_valid && issue_tid == 2'd1) cnt++;
         tick();
      end
      chk("t1_blocked_issues", cnt, 0);
      wake_valid = 1; wake_tid = 2'd1;
      tick();
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (issue_valid && issue_tid == 2'd1) begin
            found = 1;
            chk("t1_wake_pc", issue_pc, 32'h100);
         end else tick();
      end
      chk("t1_woken_issues", found, 1);

      // Blocking retire and wake for thread 2 in the same cycle.
      ctl_wait[2] = 1; ctl_wake[2] = 1;
      n = 0;
      while (retired_tid != 2 && n < 20) begin tick(); n++; end
      if (retired_tid != 2) timeout("t2_retire");
      exp_pc2 = m_pc[2];
      found = 0;
      for (int i = 0; i < 5 && !found; i++) begin
         if (issue_valid && issue_tid == 2'd2) begin
            found = 1;
            chk("t2_race_pc", issue_pc, exp_pc2);
         end else tick();
      end
      chk("t2_race_issues", found, 1);

      // Reset mid-run with thread 1 waiting.
      ctl_wait[1] = 1;
      n = 0;
      while (m_st[1] != S_WAIT && n < 20) begin tick(); n++; end
      if (m_st[1] != S_WAIT) timeout("t1_wait_again");
      pulse_reset();
      chk("rel_issue_tid", issue_tid, 0);
      chk("rel_issue_pc", issue_pc, 0);

      // Stray retire for idle thread 3 must change nothing.
      manual_wb = 1;
      wb_valid = 1; wb_tid = 2'd3; wb_next_pc = 32'hDEAD; wb_halt = 1; wb_code = 32'h55;
      tick(); tick(); tick();
      chk("stray_t3_valid", issue_valid, 1);
      chk("stray_t3_tid", issue_tid, 3);
      chk("stray_t3_pc", issue_pc, 0);
      chk("stray_exitcode", exitcode, 0);

      // Halts in order t3(7), t0(9), t1, t2.
      ctl_halt[3] = 1; ctl_code[3] = 32'd7;
      n = 0;
      while (m_st[3] != S_HALT && n < 40) begin tick(); n++; end
      if (m_st[3] != S_HALT) timeout("t3_halt");
      chk("exit_after_t3", exit, 0);
      ctl_halt[0] = 1; ctl_code[0] = 32'd9;
      n = 0;
      while (m_st[0] != S_HALT && n < 40) begin tick(); n++; end
      if (m_st[0] != S_HALT) timeout("t0_halt");
      chk("exitcode_first", exitcode, 7);
      ctl_halt[1] = 1; ctl_code[1] = 32'd1;
      n = 0;
      while (m_st[1] != S_HALT && n < 40) begin tick(); n++; end
      if (m_st[1] != S_HALT) timeout("t1_halt");
      ctl_halt[2] = 1; ctl_code[2] = 32'd2;
      n = 0;
      while (m_st[2] != S_HALT && n < 40) begin tick(); n++; end
      if (m_st[2] != S_HALT) timeout("t2_halt");
      chk("exit_not_early", exit, 0);
      tick();
      chk("exit_set", exit, 1);
      chk("exitcode_kept", exitcode, 7);
      tick(); tick(); tick();
      chk("exit_sticky", exit, 1);
      chk("exitcode_sticky", exitcode, 7);
      chk("halted_no_issue", issue_valid, 0);

      // Randomised traffic against the model.
      pulse_reset();
      chk("rst2_exit", exit, 0);
      rand_mode = 1;
      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            wake_valid = 1; wake_tid = 2'($urandom_range(0, 3));
         end
         if (!head_due() && $urandom_range(0, 7) == 0) begin
            int s = $urandom_range(0, 3);
            if (!m_busy[s]) begin
               manual_wb = 1;
               wb_valid = 1; wb_tid = 2'(s); wb_next_pc = $urandom;
               wb_wait = $urandom_range(0, 1) == 1; wb_halt = $urandom_range(0, 1) == 1;
               wb_code = $urandom;
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/barrel_sched.md
BARREL_SCHED -- requirements
Module: barrel_sched

Interface
REQ-001 SHALL have parameter NTHREADS, default 4, number of hardware threads (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, start PC of every thread.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port issue_valid  out  1  current slot carries a live thread.
REQ-006 SHALL have port issue_tid  out  TID_W  thread issued this cycle; TID_W=$clog2(NTHREADS).
REQ-007 SHALL have port issue_pc  out  32  PC of issued thread.
REQ-008 SHALL have port wb_valid  in  1  retire event for wb_tid.
REQ-009 SHALL have port wb_tid  in  TID_W  retiring thread.
REQ-010 SHALL have port wb_next_pc  in  32  PC the retiring thread resumes at.
REQ-011 SHALL have port wb_wait  in  1  retiring thread blocks until woken.
REQ-012 SHALL have port wb_halt  in  1  retiring thread executed exit.
REQ-013 SHALL have port wb_code  in  32  exit code accompanying wb_halt.
REQ-014 SHALL have port wake_valid  in  1  wake request for wake_tid.
REQ-015 SHALL have port wake_tid  in  TID_W  thread to wake.
REQ-016 SHALL have port exit  out  1  all threads halted.
REQ-017 SHALL have port exitcode  out  32  latched exit code.

Function
REQ-018 SHALL keep per-thread state RUN, WAIT, HALT, a busy (in-flight) flag and a 32-bit PC register.
REQ-019 SHALL, in default mode, advance slot pointer by one mod NTHREADS every cycle, wrapping NTHREADS-1 -> 0.
REQ-020 SHALL drive issue_valid=1, issue_tid=slot, issue_pc=pc[slot] combinationally when state[slot]==RUN and busy[slot]==0; otherwise issue_valid=0 (bubble), issue_tid=slot.
REQ-021 SHALL set busy[t] on the cycle t issues and clear it on wb_valid for t.
REQ-022 SHALL on wb_valid: pc[wb_tid]<=wb_next_pc; state<=HALT if wb_halt, else WAIT if wb_wait, else RUN; wb_halt has priority over wb_wait.
REQ-023 SHALL on wake_valid move WAIT->RUN; wake to RUN or HALT thread is ignored.
REQ-024 SHALL, when wake_valid and wb_valid with wb_wait target the same thread in one cycle, end in RUN (no lost wakeup).
REQ-025 SHALL, when wb_valid with wb_halt and wake_valid target the same thread in one cycle, end in HALT.
REQ-026 SHALL latch exitcode<=wb_code on the first wb_halt event after reset only; later halts do not change it.
REQ-027 SHALL assert exit registered, one cycle after the last thread enters HALT; exit and exitcode sticky until reset.
REQ-028 SHALL never issue a HALT thread; HALT is left only by reset.
REQ-029 SHALL ignore wb_valid for a thread whose busy flag is clear (no state or PC change).

Reset
REQ-030 SHALL on resetn low asynchronously set all threads RUN, busy=0, pc=RESET_PC, slot=0, exit=0, exitcode=0.
REQ-031 SHALL, on first rising clk after resetn deasserts, issue thread 0 at RESET_PC; assertion mid-operation discards in-flight state.

Configuration
REQ-032 SHALL, with BARREL_SCHED_SKIP_EN defined, issue the next issuable thread (RUN, not busy) after the last issued thread in round-robin order, no bubbles while any thread is issuable; pointer holds when none issuable.
REQ-033 SHALL, without BARREL_SCHED_SKIP_EN, use strict fixed rotation of REQ-019/020.

Structure
REQ-034 SHALL place thread_state_t enum (RUN, WAIT, HALT) and TID_W computation in shared package barrel_pkg.
REQ-035 SHALL implement skip selection in sub-module rr_pick (request mask plus last-grant in, one-hot grant and valid out), instantiated only under BARREL_SCHED_SKIP_EN.

Verification
REQ-036 SHALL cover reset release, NTHREADS=4, RESET_PC=0, retire each issue 2 cycles later with next_pc=pc+4 -> tids 0,1,2,3,0 with pc 0,0,0,0,4.
REQ-037 SHALL cover thread 1 retiring with wb_wait=1 -> slot 1 bubbles (default) or skipped (SKIP_EN) until wake_valid tid 1, then issues at wb_next_pc.
REQ-038 SHALL cover wb_wait and wake_valid for thread 2 in same cycle -> thread 2 issues on its next slot.
REQ-039 SHALL cover halts in order t3 code 7, t0 code 9, t1, t2 -> exit=1 one cycle after t2 halts, exitcode=7, sticky.
REQ-040 SHALL cover resetn pulsed low mid-run with thread 1 in WAIT -> all RUN at pc 0, exit=0, thread 0 issues first.
REQ-041 SHALL cover stray wb_valid for non-busy thread -> no state or PC change.
